// File: rtl/gf16_reduce.sv
// ---------------------------------------------------------------------------
// gf16_reduce
// Iterative reducer for GF(2^16). Takes the 31-bit carry-less product from the
// upstream 16x16 polynomial multiplier and reduces it modulo POLY. Each BUSY
// cycle clears BITS_PER_CYCLE high-order bits. The latency is fixed at
// 15/BITS_PER_CYCLE cycles and does not depend on the operand value.
//
// Parameters
//   POLY            degree-16 field polynomial (bit 16 must be set)
//   BITS_PER_CYCLE  high bits cleared per BUSY cycle (1, 3, 5 or 15)
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_prod carries an operand
//   in_ready   block is idle and can accept an operand
//   in_prod    31-bit carry-less product, bit i = coefficient of x^i
//   out_valid  out_data holds a reduced result
//   out_ready  downstream accepts the result
//   out_data   in_prod mod POLY (reads zero while out_valid is low)
//   busy       high while an operation is in flight (BUSY or DONE)
// ---------------------------------------------------------------------------
module gf16_reduce #(
    parameter logic [16:0] POLY           = 17'h1002D,
    parameter int          BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] in_prod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);

    localparam int STEPS = 15 / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [30:0] POLY_EXT = {14'd0, POLY};

    // Reject parameter values that would silently produce a wrong field.
    if (POLY[16] !== 1'b1) begin : g_bad_poly
        $error("gf16_reduce: POLY must have bit 16 set");
    end
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 3 ||
          BITS_PER_CYCLE == 5 || BITS_PER_CYCLE == 15)) begin : g_bad_bpc
        $error("gf16_reduce: BITS_PER_CYCLE must be 1, 3, 5 or 15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [30:0]       r_q, r_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       out_data_q, out_data_d;

    logic [30:0]       r_step;
    logic [4:0]        k_top;
    logic [4:0]        k;

    // One BUSY cycle of long division: walk down from bit 30-cnt*B, and
    // wherever the running remainder has a 1 at bit k, cancel it with
    // POLY aligned so its x^16 term lands on bit k. The lowest k reached
    // is 16, so the shift is never negative and POLY never passes bit 30.
    always_comb begin
        r_step = r_q;
        k_top  = 5'(30 - int'(cnt_q) * BITS_PER_CYCLE);
        k      = k_top;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            k = k_top - 5'(j);
            if (r_step[k]) begin
                r_step = r_step ^ (POLY_EXT << (k - 5'd16));
            end
        end
    end

    // Next-state logic. The result is latched into out_data when BUSY
    // finishes and cleared again on the output transfer, so out_data is
    // zero whenever out_valid is low.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_d     = in_prod;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                r_d   = r_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d    = DONE;
                    out_data_d = r_step[15:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d    = IDLE;
                    out_data_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset takes priority over any handshake in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            r_q        <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    // After the last step every bit above x^15 must have been cleared.
    always @(posedge clk) begin
        if (!rst && state_q == BUSY && cnt_q == LAST_STEP) begin
            assert (r_step[30:16] == 15'd0);
        end
    end

    // All outputs decode registered state only, so there is no
    // combinational path from in_valid or out_ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;

endmodule
